spi_reg_ctrl: RTL and testbench

Command/register controller that sits behind the byte-level SPI slave and sequences every SPI message into register reads and writes. It decodes the first byte of each message as a command, then streams data bytes into or out of a 16-entry configuration register file that drives the vision pipeline (thresholds, exposure, mode bits). It also supplies the byte the SPI slave shifts out on MISO. The top-level address is read-only live status.

---
 rtl/spi_reg_ctrl.sv | 129 ++++++++++++
 tb/tb_spi_reg_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command/register controller behind a byte-level SPI slave.
// The first byte of each message is a command; following bytes stream into
// (write) or out of (read) a small configuration register file. The top
// address is read-only and returns live status.
//
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   msg_start/msg_end - one-cycle pulses framing a message (SSEL edges)
//   byte_ready/rx_byte- one-cycle pulse with a complete received byte
//   status_in         - live status, readable at address NUM_REGS-1
//   tx_byte           - next byte for the SPI slave to shift out
//   reg_wr_*          - one-cycle pulse + address/data per committed write
//   cfg_flat          - all registers, reg k at [8k+7:8k], top slot reads 0
//   err_cnt           - saturating count of illegal commands
module spi_reg_ctrl #(
    parameter int          NUM_REGS = 16,
    parameter logic [7:0]  ID_BYTE  = 8'hA5,
    parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  msg_start,
    input  logic                  msg_end,
    input  logic                  byte_ready,
    input  logic [7:0]            rx_byte,
    input  logic [7:0]            status_in,
    output logic [7:0]            tx_byte,
    output logic                  reg_wr_en,
    output logic [3:0]            reg_wr_addr,
    output logic [7:0]            reg_wr_data,
    output logic [NUM_REGS*8-1:0] cfg_flat,
    output logic [7:0]            err_cnt
);

    localparam int             AW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AW-1:0]  LAST = AW'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, ERR} state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic          ai;
    logic [7:0]    regs [NUM_REGS];

    // Command decode of the current rx_byte (only meaningful in CMD)
    logic          cmd_illegal;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] ptr_inc;

    assign cmd_illegal = (rx_byte[5:4] != 2'b00) || (int'(rx_byte[3:0]) >= NUM_REGS);
    assign cmd_addr    = rx_byte[AW-1:0];
    assign ptr_inc     = ptr + AW'(1);

    // Read mux: top address is live status, never the stored slot
    function automatic logic [7:0] rd(input logic [AW-1:0] a);
        return (a == LAST) ? status_in : regs[a];
    endfunction

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        if (k == NUM_REGS - 1) begin : g_ro
            assign cfg_flat[8*k +: 8] = 8'h00;
        end else begin : g_rw
            assign cfg_flat[8*k +: 8] = regs[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            ai          <= 1'b0;
            tx_byte     <= 8'h00;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= 4'h0;
            reg_wr_data <= 8'h00;
            err_cnt     <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            reg_wr_en <= 1'b0;
            if (msg_start) begin
                // A new message wins over any byte or end pulse this cycle
                state   <= CMD;
                tx_byte <= ID_BYTE;
            end else begin
                if (byte_ready) begin
                    case (state)
                        CMD: begin
                            ptr <= cmd_addr;
                            ai  <= rx_byte[6];
                            if (cmd_illegal) begin
                                state   <= ERR;
                                tx_byte <= ERR_BYTE;
                                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                            end else if (rx_byte[7]) begin
                                state   <= READ;
                                tx_byte <= rd(cmd_addr);
                            end else begin
                                state   <= WRITE;
                                tx_byte <= 8'h00;
                            end
                        end
                        WRITE: begin
                            if (ptr != LAST) begin
                                regs[ptr]   <= rx_byte;
                                reg_wr_en   <= 1'b1;
                                reg_wr_addr <= 4'(ptr);
                                reg_wr_data <= rx_byte;
                            end
                            if (ai) ptr <= ptr_inc;
                            tx_byte <= rx_byte;   // echo for link check
                        end
                        READ: begin
                            if (ai) begin
                                ptr     <= ptr_inc;
                                tx_byte <= rd(ptr_inc);
                            end else begin
                                tx_byte <= rd(ptr);
                            end
                        end
                        default: ;                // IDLE and ERR ignore bytes
                    endcase
                end
                // Placed after byte handling so a coincident byte is still processed
                if (msg_end) state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         msg_start, msg_end, byte_ready;
    logic [7:0]   rx_byte, status_in;
    logic [7:0]   tx_byte;
    logic         reg_wr_en;
    logic [3:0]   reg_wr_addr;
    logic [7:0]   reg_wr_data;
    logic [127:0] cfg_flat;
    logic [7:0]   err_cnt;

    int errors = 0;
    int checks = 0;

    spi_reg_ctrl #(.NUM_REGS(16), .ID_BYTE(8'hA5), .ERR_BYTE(8'hEE)) dut (
        .clk(clk), .rst(rst), .msg_start(msg_start), .msg_end(msg_end),
        .byte_ready(byte_ready), .rx_byte(rx_byte), .status_in(status_in),
        .tx_byte(tx_byte), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .cfg_flat(cfg_flat), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs; returns 1 time unit after the sampling edge
    task automatic pulse(input logic s, input logic br, input logic e, input logic [7:0] b);
        msg_start = s; byte_ready = br; msg_end = e; rx_byte = b;
        @(posedge clk); #1;
        msg_start = 0; byte_ready = 0; msg_end = 0; rx_byte = 8'h00;
    endtask

    task automatic test_reset;
        rst = 1; msg_start = 0; msg_end = 0; byte_ready = 0; rx_byte = 0; status_in = 8'h81;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx got=%h exp=00", tx_byte); end
        checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", reg_wr_en); end
        checks++; if (cfg_flat !== 128'h0) begin errors++; $display("FAIL reset_cfg got=%h exp=0", cfg_flat); end
        checks++; if (err_cnt !== 8'h00 || reg_wr_addr !== 4'h0 || reg_wr_data !== 8'h00) begin
            errors++; $display("FAIL reset_misc got=%h/%h/%h exp=00/0/00", err_cnt, reg_wr_addr, reg_wr_data); end
        rst = 0;
    endtask

    task automatic test_burst_write;
        logic [7:0] d [3];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
        pulse(1, 0, 0, 8'h00);
        checks++; if (tx_byte !== 8'hA5) begin errors++; $display("FAIL bw_id got=%h exp=A5", tx_byte); end
        pulse(0, 1, 0, 8'h42);
        checks++; if (tx_byte !== 8'h00 || reg_wr_en !== 1'b0) begin
            errors++; $display("FAIL bw_cmd got=%h/%b exp=00/0", tx_byte, reg_wr_en); end
        for (int i = 0; i < 3; i++) begin
            pulse(0, 1, 0, d[i]);
            checks++;
            if (reg_wr_en !== 1'b1 || reg_wr_addr !== 4'(i + 2) || reg_wr_data !== d[i] || tx_byte !== d[i]) begin
                errors++; $display("FAIL bw_data%0d got=%b/%h/%h/%h exp=1/%h/%h/%h",
                    i, reg_wr_en, reg_wr_addr, reg_wr_data, tx_byte, 4'(i + 2), d[i], d[i]);
            end
            pulse(0, 0, 0, 8'h00);
            checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL bw_pulse%0d got=1 exp=0", i); end
        end
        checks++; if (cfg_flat[39:16] !== 24'h332211) begin
            errors++; $display("FAIL bw_cfg got=%h exp=332211", cfg_flat[39:16]); end
        pulse(0, 0, 1, 8'h00);
    endtask

    task automatic test_wrap_read;
        logic [7:0] exp [4];
        exp[0] = 8'h5C; exp[1] = 8'h81; exp[2] = 8'h00; exp[3] = 8'h00;
        // preset reg14
        pulse(1, 0, 0, 8'h00);
        pulse(0, 1, 0, 8'h0E);
        pulse(0, 1, 1, 8'h5C);
        checks++; if (cfg_flat[119:112] !== 8'h5C) begin
            errors++; $display("FAIL wr_preset got=%h exp=5C", cfg_flat[119:112]); end
        status_in = 8'h81;
        pulse(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            pulse(0, 1, 0, (i == 0) ? 8'hCE : 8'h3F);
            checks++;
            if (tx_byte !== exp[i] || reg_wr_en !== 1'b0) begin
                errors++; $display("FAIL wr_read%0d got=%h/%b exp=%h/0", i, tx_byte, reg_wr_en, exp[i]);
            end
        end
        pulse(0, 0, 1, 8'h00);
    endtask

    task automatic test_illegal;
        pulse(1, 0, 0, 8'h00);
        pulse(0, 1, 0, 8'h30);
        checks++; if (tx_byte !== 8'hEE || err_cnt !== 8'd1) begin
            errors++; $display("FAIL ill_cmd got=%h/%0d exp=EE/1", tx_byte, err_cnt); end
        pulse(0, 1, 0, 8'h99);
        checks++; if (tx_byte !== 8'hEE || reg_wr_en !== 1'b0 || err_cnt !== 8'd1) begin
            errors++; $display("FAIL ill_data got=%h/%b/%0d exp=EE/0/1", tx_byte, reg_wr_en, err_cnt); end
        pulse(0, 0, 1, 8'h00);
        for (int i = 1; i < 300; i++) begin
            pulse(1, 0, 0, 8'h00);
            pulse(0, 1, 0, 8'h30);
            pulse(0, 0, 1, 8'h00);
        end
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL ill_sat got=%0d exp=255", err_cnt); end
        checks++; if (cfg_flat[39:16] !== 24'h332211) begin
            errors++; $display("FAIL ill_regs got=%h exp=332211", cfg_flat[39:16]); end
    endtask

    task automatic test_ro_drop;
        status_in = 8'h3C;
        pulse(1, 0, 0, 8'h00);
        pulse(0, 1, 0, 8'h0F);
        pulse(0, 1, 0, 8'h77);
        checks++; if (reg_wr_en !== 1'b0 || tx_byte !== 8'h77) begin
            errors++; $display("FAIL ro_drop got=%b/%h exp=0/77", reg_wr_en, tx_byte); end
        checks++; if (cfg_flat[127:120] !== 8'h00) begin
            errors++; $display("FAIL ro_cfg got=%h exp=00", cfg_flat[127:120]); end
        pulse(0, 0, 1, 8'h00);
        pulse(1, 0, 0, 8'h00);
        pulse(0, 1, 0, 8'h8F);
        checks++; if (tx_byte !== 8'h3C) begin errors++; $display("FAIL ro_status got=%h exp=3C", tx_byte); end
        pulse(0, 0, 1, 8'h00);
    endtask

    task automatic test_abort_simul;
        pulse(1, 0, 0, 8'h00);
        pulse(0, 1, 0, 8'h45);
        pulse(0, 1, 0, 8'hAA);
        checks++; if (reg_wr_en !== 1'b1 || reg_wr_addr !== 4'd5) begin
            errors++; $display("FAIL ab_first got=%b/%h exp=1/5", reg_wr_en, reg_wr_addr); end
        pulse(1, 0, 0, 8'h00);                    // abort mid-write
        checks++; if (tx_byte !== 8'hA5 || cfg_flat[47:40] !== 8'hAA) begin
            errors++; $display("FAIL ab_keep got=%h/%h exp=A5/AA", tx_byte, cfg_flat[47:40]); end
        pulse(0, 1, 0, 8'h06);                    // accepted as a command -> in CMD
        checks++; if (tx_byte !== 8'h00 || reg_wr_en !== 1'b0) begin
            errors++; $display("FAIL ab_cmd got=%h/%b exp=00/0", tx_byte, reg_wr_en); end
        pulse(0, 1, 0, 8'hBB);
        checks++; if (reg_wr_en !== 1'b1 || reg_wr_addr !== 4'd6 || reg_wr_data !== 8'hBB) begin
            errors++; $display("FAIL ab_wr6 got=%b/%h/%h exp=1/6/BB", reg_wr_en, reg_wr_addr, reg_wr_data); end
        pulse(1, 1, 0, 8'hCC);                    // start + byte: byte dropped
        checks++; if (reg_wr_en !== 1'b0 || tx_byte !== 8'hA5 || cfg_flat[55:48] !== 8'hBB) begin
            errors++; $display("FAIL sim_start got=%b/%h/%h exp=0/A5/BB", reg_wr_en, tx_byte, cfg_flat[55:48]); end
        pulse(0, 1, 0, 8'h07);
        pulse(0, 1, 1, 8'hDD);                    // byte + end: committed
        checks++; if (reg_wr_en !== 1'b1 || reg_wr_addr !== 4'd7 || reg_wr_data !== 8'hDD) begin
            errors++; $display("FAIL sim_end got=%b/%h/%h exp=1/7/DD", reg_wr_en, reg_wr_addr, reg_wr_data); end
        pulse(0, 1, 0, 8'h12);                    // IDLE ignores bytes
        checks++; if (reg_wr_en !== 1'b0 || tx_byte !== 8'hDD || cfg_flat[63:56] !== 8'hDD) begin
            errors++; $display("FAIL sim_idle got=%b/%h/%h exp=0/DD/DD", reg_wr_en, tx_byte, cfg_flat[63:56]); end
        pulse(1, 0, 1, 8'h00);                    // start + end: start wins
        pulse(0, 1, 0, 8'h09);
        pulse(0, 1, 1, 8'h5A);
        checks++; if (reg_wr_en !== 1'b1 || reg_wr_addr !== 4'd9) begin
            errors++; $display("FAIL sim_se got=%b/%h exp=1/9", reg_wr_en, reg_wr_addr); end
    endtask

    task automatic test_reset_mid;
        pulse(1, 0, 0, 8'h00);
        pulse(0, 1, 0, 8'h48);
        pulse(0, 1, 0, 8'h55);
        rst = 1;
        pulse(0, 1, 0, 8'h66);
        rst = 0;
        checks++; if (tx_byte !== 8'h00 || reg_wr_en !== 1'b0 || cfg_flat !== 128'h0 || err_cnt !== 8'h00
                      || reg_wr_addr !== 4'h0 || reg_wr_data !== 8'h00) begin
            errors++; $display("FAIL rm_reset got=%h/%b/%h/%h exp=00/0/0/00", tx_byte, reg_wr_en, cfg_flat, err_cnt); end
        pulse(0, 1, 0, 8'h66);
        checks++; if (reg_wr_en !== 1'b0 || tx_byte !== 8'h00 || cfg_flat !== 128'h0) begin
            errors++; $display("FAIL rm_ignore got=%b/%h/%h exp=0/00/0", reg_wr_en, tx_byte, cfg_flat); end
    endtask

    initial begin
        test_reset();
        test_burst_write();
        test_wrap_read();
        test_illegal();
        test_ro_drop();
        test_abort_simul();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
